placer_host_link: RTL and testbench

- Host-side driver of the placer's load/unload shift interface.
- Accepts a valid/ready word stream from the host and shifts it into the placer via load_enable_in/load_in.
- Waits for placer complete, then shifts the result words out of unload_out into a valid/ready output stream.
- Sits between the host DMA/FIFO fabric and the placer top level; one instance per placer.

---
 rtl/placer_host_link_if.sv | 26 ++
 rtl/placer_host_link.sv | 144 ++++++++++++++
 tb/tb_placer_host_link.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/placer_host_link_if.sv
// Host streams and placer load/unload shift bus seen by placer_host_link.
// slave is the link side; master is the host fabric plus placer.
interface placer_host_link_if #(
    parameter int BUS_WIDTH = 32
);
    logic [BUS_WIDTH-1:0] s_data;
    logic                 s_valid;
    logic                 s_ready;
    logic [BUS_WIDTH-1:0] m_data;
    logic                 m_valid;
    logic                 m_ready;
    logic                 plc_load_enable;
    logic [BUS_WIDTH-1:0] plc_load_data;
    logic                 plc_complete;
    logic [BUS_WIDTH-1:0] plc_unload;

    modport slave (
        input  s_data, s_valid, m_ready, plc_complete, plc_unload,
        output s_ready, m_data, m_valid, plc_load_enable, plc_load_data
    );

    modport master (
        output s_data, s_valid, m_ready, plc_complete, plc_unload,
        input  s_ready, m_data, m_valid, plc_load_enable, plc_load_data
    );
endinterface

// File: rtl/placer_host_link.sv
// Shifts one problem into the placer, waits for completion (with watchdog),
// then shifts the result out into a valid/ready stream.
module placer_host_link #(
    parameter int BUS_WIDTH      = 32,
    parameter int LOAD_WORDS     = 64,
    parameter int UNLOAD_WORDS   = 64,
    parameter int MAX_RUN_CYCLES = 1048576
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    placer_host_link_if.slave   bus,
    output logic                busy,
    output logic                done,
    output logic                error
);
    // state    | meaning
    // S_IDLE   | waiting for start, counters held clear
    // S_LOAD   | passing host words straight onto the load chain
    // S_RUN    | waiting for plc_complete or watchdog expiry
    // S_UNLOAD | shifting result words out to the host stream
    // S_DONE   | one-cycle done pulse

    localparam int LW_W = $clog2(LOAD_WORDS + 1);
    localparam int UW_W = $clog2(UNLOAD_WORDS + 1);
    localparam int RW_W = $clog2(MAX_RUN_CYCLES + 1);

    localparam logic [LW_W-1:0] LOAD_LAST  = LW_W'(LOAD_WORDS - 1);
    localparam logic [LW_W-1:0] LOAD_ALL   = LW_W'(LOAD_WORDS);
    localparam logic [UW_W-1:0] UNLOAD_ALL = UW_W'(UNLOAD_WORDS);
    localparam logic [RW_W-1:0] RUN_LAST   = RW_W'(MAX_RUN_CYCLES - 1);
    localparam logic [RW_W-1:0] RUN_ALL    = RW_W'(MAX_RUN_CYCLES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_UNLOAD,
        S_DONE
    } state_t;

    state_t               state, state_nxt;
    logic [LW_W-1:0]      load_cnt;
    logic [UW_W-1:0]      unload_cnt;
    logic [RW_W-1:0]      run_cnt;
    logic [BUS_WIDTH-1:0] m_data_q;
    logic                 m_valid_q;
    logic                 xfer;
    logic                 shift;
    logic                 out_free;
    logic                 watchdog;

    assign bus.m_data  = m_data_q;
    assign bus.m_valid = m_valid_q;
    assign busy        = (state != S_IDLE);

    always_comb begin
        state_nxt           = state;
        bus.s_ready         = 1'b0;
        bus.plc_load_enable = 1'b0;
        bus.plc_load_data   = '0;
        done                = 1'b0;
        xfer                = 1'b0;
        shift               = 1'b0;
        watchdog            = 1'b0;
        out_free            = !m_valid_q || bus.m_ready;
        unique case (state)
            S_IDLE: begin
                if (start) state_nxt = S_LOAD;
            end
            S_LOAD: begin
                bus.s_ready = 1'b1;
                xfer        = bus.s_valid;
                if (xfer) begin
                    bus.plc_load_enable = 1'b1;
                    bus.plc_load_data   = bus.s_data;
                    if (load_cnt == LOAD_LAST) state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                // first RUN cycle may still see the previous problem's complete
                if (run_cnt != '0 && bus.plc_complete) begin
                    state_nxt = S_UNLOAD;
                end else if (run_cnt == RUN_LAST) begin
                    watchdog  = 1'b1;
                    state_nxt = S_UNLOAD;
                end
            end
            S_UNLOAD: begin
                if (unload_cnt < UNLOAD_ALL && out_free) begin
                    shift               = 1'b1;
                    bus.plc_load_enable = 1'b1;
                end else if (unload_cnt == UNLOAD_ALL && out_free) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            load_cnt   <= '0;
            unload_cnt <= '0;
            run_cnt    <= '0;
            m_data_q   <= '0;
            m_valid_q  <= 1'b0;
            error      <= 1'b0;
        end else begin
            state <= state_nxt;
            unique case (state)
                S_IDLE: begin
                    load_cnt   <= '0;
                    unload_cnt <= '0;
                    run_cnt    <= '0;
                    if (start) error <= 1'b0;
                end
                S_LOAD: begin
                    if (xfer && load_cnt != LOAD_ALL) load_cnt <= load_cnt + 1'b1;
                end
                S_RUN: begin
                    if (run_cnt != RUN_ALL) run_cnt <= run_cnt + 1'b1;
                    if (watchdog) error <= 1'b1;
                end
                S_UNLOAD: begin
                    // never shift while a word is still held, so backpressure loses nothing
                    if (shift) begin
                        m_data_q   <= bus.plc_unload;
                        m_valid_q  <= 1'b1;
                        unload_cnt <= unload_cnt + 1'b1;
                    end else if (m_valid_q && bus.m_ready) begin
                        m_valid_q <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_placer_host_link.sv
// Randomized bench for placer_host_link: a queue-based placer chain plus
// host source/sink, with expected timing derived from word and cycle counts.
module tb_placer_host_link;
    localparam int BW   = 32;
    localparam int LW   = 4;
    localparam int UW   = 4;
    localparam int MAXR = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start = 1'b0;
    logic busy, done, error;

    placer_host_link_if #(.BUS_WIDTH(BW)) bus ();

    placer_host_link #(
        .BUS_WIDTH(BW), .LOAD_WORDS(LW), .UNLOAD_WORDS(UW), .MAX_RUN_CYCLES(MAXR)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .bus(bus),
        .busy(busy), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    // sequence bookkeeping in cycle numbers
    bit seq_on;
    int s_cyc, t_cyc, u_cyc, e_cyc;
    int nload, nunl, nacc;
    int n_le, n_hs, n_done;
    int gmode, rmode, cmp_from;
    bit stale, wd, err_exp;
    logic [BW-1:0] src_q[$], sent_q[$], chain_q[$], res_q[$], exp_q[$];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic reset_model();
        seq_on = 1'b0; s_cyc = 0; t_cyc = -1; u_cyc = -1; e_cyc = -1;
        nload = 0; nunl = 0; nacc = 0; wd = 1'b0; err_exp = 1'b0;
    endtask

    task automatic do_cycle(input bit st);
        bit busy_e, in_load, ld, last_now, in_unl, mv, free, shift_e, end_e, done_e, v, r, c;
        int dc;
        @(negedge clk);
        busy_e  = seq_on && cyc > s_cyc && !(e_cyc >= 0 && cyc > e_cyc + 1);
        in_load = seq_on && cyc > s_cyc && nload < LW;
        start   = st;
        case (gmode)
            0: v = 1'b1;
            1: v = ((cyc - s_cyc - 1) % 2 == 0);
            default: v = 1'($urandom_range(0, 1));
        endcase
        bus.s_valid = v && src_q.size() > 0;
        bus.s_data  = (src_q.size() > 0) ? src_q[0] : $urandom;
        case (rmode)
            0: r = 1'b1;
            1: r = !(u_cyc >= 0 && cyc >= u_cyc + 1 && cyc <= u_cyc + 5);
            default: r = 1'($urandom_range(0, 1));
        endcase
        bus.m_ready = r;
        last_now = in_load && bus.s_valid && nload == LW - 1;
        c = stale && (last_now || (t_cyc >= 0 && cyc == t_cyc + 1));
        if (t_cyc >= 0 && e_cyc < 0 && cyc - t_cyc >= cmp_from) c = 1'b1;
        bus.plc_complete = c;
        bus.plc_unload   = chain_q[0];
        if (cyc == u_cyc) exp_q = chain_q;
        in_unl  = u_cyc >= 0 && cyc >= u_cyc && e_cyc < 0;
        mv      = nunl > nacc;
        free    = !mv || bus.m_ready;
        shift_e = in_unl && nunl < UW && free;
        end_e   = in_unl && nunl == UW && free;
        done_e  = e_cyc >= 0 && cyc == e_cyc + 1;
        ld      = in_load && bus.s_valid;
        #1;
        check_eq("s_ready", bus.s_ready, in_load);
        check_eq("load_enable", bus.plc_load_enable, ld || shift_e);
        check_eq("load_data", bus.plc_load_data, ld ? bus.s_data : '0);
        check_eq("m_valid", bus.m_valid, mv);
        if (mv) check_eq("m_data", bus.m_data, exp_q[nacc]);
        check_eq("busy", busy, busy_e);
        check_eq("done", done, done_e);
        check_eq("error", error, err_exp);

        if (st && !busy_e) begin
            seq_on = 1'b1; s_cyc = cyc; t_cyc = -1; u_cyc = -1; e_cyc = -1;
            nload = 0; nunl = 0; nacc = 0; err_exp = 1'b0;
            n_le = 0; n_hs = 0; n_done = 0;
        end
        if (bus.plc_load_enable) n_le++;
        if (bus.m_valid && bus.m_ready) n_hs++;
        if (done) n_done++;
        if (bus.plc_load_enable) begin
            chain_q.push_back(bus.plc_load_data);
            void'(chain_q.pop_front());
        end
        if (ld) begin
            void'(src_q.pop_front());
            nload++;
            if (nload == LW) begin
                t_cyc = cyc;
                dc    = (cmp_from > 2) ? cmp_from : 2;
                wd    = dc > MAXR;
                u_cyc = cyc + (wd ? MAXR + 1 : dc + 1);
                for (int i = 0; i < LW; i++) check_eq("chain_loaded", chain_q[i], sent_q[i]);
            end
        end
        if (!wd && t_cyc >= 0 && cyc == t_cyc + cmp_from) chain_q = res_q;
        if (wd && t_cyc >= 0 && cyc == t_cyc + MAXR) err_exp = 1'b1;
        if (shift_e) nunl++;
        if (mv && bus.m_ready) nacc++;
        if (end_e) e_cyc = cyc;
        @(posedge clk);
        cyc++;
    endtask

    task automatic run_seq(input int g, input int r, input int cf, input bit stl,
                           input bit poke, input int stop_acc);
        int guard;
        guard = 0;
        gmode = g; rmode = r; cmp_from = cf; stale = stl;
        src_q.delete(); chain_q.delete(); res_q.delete();
        for (int i = 0; i < LW; i++) begin
            src_q.push_back($urandom);
            chain_q.push_back($urandom);
        end
        for (int i = 0; i < UW; i++) res_q.push_back($urandom);
        sent_q = src_q;
        do_cycle(1'b1);
        while (!(e_cyc >= 0 && cyc > e_cyc + 1) && guard < 200) begin
            if (stop_acc >= 0 && nacc >= stop_acc) return;
            do_cycle(poke && $urandom_range(0, 3) == 0);
            guard++;
        end
        check_eq("seq_timeout", guard < 200, 1'b1);
        check_eq("enable_pulses", n_le, LW + UW);
        check_eq("handshakes", n_hs, UW);
        check_eq("done_pulses", n_done, 1);
    endtask

    initial begin
        bus.s_data = '0; bus.s_valid = 1'b0; bus.m_ready = 1'b0;
        bus.plc_complete = 1'b0; bus.plc_unload = '0;
        reset_model();
        for (int i = 0; i < LW; i++) chain_q.push_back('0);
        #2;
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_m_valid", bus.m_valid, 1'b0);
        check_eq("rst_m_data", bus.m_data, '0);
        check_eq("rst_s_ready", bus.s_ready, 1'b0);
        check_eq("rst_error", error, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        run_seq(0, 0, 5, 1'b0, 1'b0, -1);     // nominal
        run_seq(1, 0, 3, 1'b0, 1'b0, -1);     // load gaps
        run_seq(0, 1, 2, 1'b0, 1'b1, -1);     // backpressure, start ignored while busy
        run_seq(0, 0, 1000, 1'b0, 1'b0, -1);  // watchdog
        check_eq("error_sticky", error, 1'b1);
        run_seq(0, 0, 5, 1'b1, 1'b0, -1);     // stale complete; also clears error
        check_eq("error_cleared", error, 1'b0);

        run_seq(0, 0, 3, 1'b0, 1'b1, 2);      // abort mid-unload
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check_eq("arst_busy", busy, 1'b0);
        check_eq("arst_done", done, 1'b0);
        check_eq("arst_error", error, 1'b0);
        check_eq("arst_s_ready", bus.s_ready, 1'b0);
        check_eq("arst_m_valid", bus.m_valid, 1'b0);
        check_eq("arst_m_data", bus.m_data, '0);
        check_eq("arst_load_enable", bus.plc_load_enable, 1'b0);
        check_eq("arst_load_data", bus.plc_load_data, '0);
        reset_model();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        run_seq(0, 0, 4, 1'b0, 1'b0, -1);

        for (int k = 0; k < 8; k++)
            run_seq(2, 2, $urandom_range(1, 10), 1'($urandom_range(0, 1)), 1'b1, -1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
